// File: rtl/load_store_unit.sv
// Load/store sequencer between a CPU request/response port and a registered data memory.
// Define LSU_ADDR_CHECK_EN to reject addresses at or beyond MEM_DEPTH with rsp_err.
module load_store_unit #(
    parameter int WORD_SIZE = 19,
    parameter int MEM_DEPTH = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [WORD_SIZE-1:0] req_addr,
    input  logic [WORD_SIZE-1:0] req_wdata,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [WORD_SIZE-1:0] rsp_rdata,
    output logic                 rsp_err,
    output logic                 WR_EN_DM,
    output logic                 RD_EN_DM,
    output logic [WORD_SIZE-1:0] address,
    output logic [WORD_SIZE-1:0] data_in,
    input  logic [WORD_SIZE-1:0] data_out,
    output logic [15:0]          rd_count,
    output logic [15:0]          wr_count
);

    // state     | meaning
    // IDLE      | ready for a request
    // READ      | RD_EN_DM pulse to memory
    // READ_WAIT | memory data arrives, captured into rsp_rdata
    // WRITE     | WR_EN_DM pulse to memory
    // RESP      | response held until rsp_ready
    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] READ      = 3'd1;
    localparam logic [2:0] READ_WAIT = 3'd2;
    localparam logic [2:0] WRITE     = 3'd3;
    localparam logic [2:0] RESP      = 3'd4;

    logic [2:0] state;
    logic [2:0] state_next;
    logic       we_q;
    logic       err_q;
    logic       req_fire;
    logic       rsp_fire;
    logic       addr_bad;

    assign req_ready = (state == IDLE);
    assign RD_EN_DM  = (state == READ);
    assign WR_EN_DM  = (state == WRITE);
    assign rsp_valid = (state == RESP);
    assign rsp_err   = err_q;

    assign req_fire = req_valid & req_ready;
    assign rsp_fire = rsp_valid & rsp_ready;

`ifdef LSU_ADDR_CHECK_EN
    // one extra bit so a MEM_DEPTH equal to 2**WORD_SIZE still compares correctly
    assign addr_bad = ({1'b0, req_addr} >= (WORD_SIZE+1)'(MEM_DEPTH));
`else
    assign addr_bad = 1'b0;
`endif

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (req_fire) begin
                    if (addr_bad)
                        state_next = RESP;
                    else if (req_we)
                        state_next = WRITE;
                    else
                        state_next = READ;
                end
            end
            READ:      state_next = READ_WAIT;
            READ_WAIT: state_next = RESP;
            WRITE:     state_next = RESP;
            RESP: begin
                if (rsp_fire)
                    state_next = IDLE;
            end
            default:   state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            we_q      <= 1'b0;
            err_q     <= 1'b0;
            address   <= '0;
            data_in   <= '0;
            rsp_rdata <= '0;
            rd_count  <= '0;
            wr_count  <= '0;
        end else begin
            state <= state_next;

            if (req_fire) begin
                address <= req_addr;
                data_in <= req_wdata;
                we_q    <= req_we;
                err_q   <= addr_bad;
                if (addr_bad)
                    rsp_rdata <= '0;
            end

            if (state == READ_WAIT)
                rsp_rdata <= data_out;
            if (state == WRITE)
                rsp_rdata <= '0;

            // erroneous responses are not counted; counters stick at all-ones
            if (rsp_fire && !err_q) begin
                if (we_q) begin
                    if (wr_count != 16'hFFFF)
                        wr_count <= wr_count + 16'd1;
                end else begin
                    if (rd_count != 16'hFFFF)
                        rd_count <= rd_count + 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a registered-read memory model.
// Address-error steps follow LSU_ADDR_CHECK_EN when it is defined.
module tb_load_store_unit;
    localparam int W = 19;

    logic         clk = 1'b0;
    logic         rst;
    logic         req_valid;
    logic         req_ready;
    logic         req_we;
    logic [W-1:0] req_addr;
    logic [W-1:0] req_wdata;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] rsp_rdata;
    logic         rsp_err;
    logic         WR_EN_DM;
    logic         RD_EN_DM;
    logic [W-1:0] address;
    logic [W-1:0] data_in;
    logic [W-1:0] data_out;
    logic [15:0]  rd_count;
    logic [15:0]  wr_count;

    int checks = 0;
    int errors = 0;
    int rd_pulses;
    int wr_pulses;
    int both_cycles;
    int p0;
    int w0;

    logic [W-1:0] mem [0:2047];

    load_store_unit #(.WORD_SIZE(W), .MEM_DEPTH(1024)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .WR_EN_DM(WR_EN_DM), .RD_EN_DM(RD_EN_DM),
        .address(address), .data_in(data_in), .data_out(data_out),
        .rd_count(rd_count), .wr_count(wr_count)
    );

    always #5 clk = ~clk;

    // memory model: read data registered, valid the cycle after RD_EN_DM
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2048; i++) mem[i] <= '0;
            data_out    <= '0;
            rd_pulses   <= 0;
            wr_pulses   <= 0;
            both_cycles <= 0;
        end else begin
            if (WR_EN_DM) mem[address[10:0]] <= data_in;
            if (RD_EN_DM) data_out <= mem[address[10:0]];
            if (RD_EN_DM) rd_pulses <= rd_pulses + 1;
            if (WR_EN_DM) wr_pulses <= wr_pulses + 1;
            if (RD_EN_DM && WR_EN_DM) both_cycles <= both_cycles + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        rsp_ready = 1'b1;
        repeat (3) tick();

        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_wr_en", WR_EN_DM, 0);
        chk("rst_rd_en", RD_EN_DM, 0);
        chk("rst_address", address, 0);
        chk("rst_data_in", data_in, 0);
        chk("rst_rdata", rsp_rdata, 0);
        chk("rst_rd_count", rd_count, 0);
        chk("rst_wr_count", wr_count, 0);
        chk("rst_req_ready", req_ready, 1);
        rst = 1'b0;
        tick();

        // store addr 5
        req_valid = 1'b1; req_we = 1'b1; req_addr = 5; req_wdata = 19'h1234A;
        chk("st_req_ready", req_ready, 1);
        tick();
        req_valid = 1'b0;
        chk("st_wr_en", WR_EN_DM, 1);
        chk("st_rd_en", RD_EN_DM, 0);
        chk("st_address", address, 5);
        chk("st_data_in", data_in, 32'h1234A);
        chk("st_rsp_valid_c1", rsp_valid, 0);
        tick();
        chk("st_wr_en_once", WR_EN_DM, 0);
        chk("st_rsp_valid_c2", rsp_valid, 1);
        chk("st_rdata_zero", rsp_rdata, 0);
        chk("st_busy", req_ready, 0);
        chk("st_err", rsp_err, 0);
        tick();
        chk("st_wr_count", wr_count, 1);
        chk("st_back_idle", rsp_valid, 0);
        chk("st_mem", mem[5], 32'h1234A);

        // load addr 5
        p0 = rd_pulses;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 5; req_wdata = 19'h7FFFF;
        tick();
        req_valid = 1'b0;
        chk("ld_rd_en", RD_EN_DM, 1);
        chk("ld_wr_en", WR_EN_DM, 0);
        chk("ld_rsp_valid_c1", rsp_valid, 0);
        tick();
        chk("ld_rd_en_c2", RD_EN_DM, 0);
        chk("ld_rsp_valid_c2", rsp_valid, 0);
        tick();
        chk("ld_rsp_valid_c3", rsp_valid, 1);
        chk("ld_rdata", rsp_rdata, 32'h1234A);
        chk("ld_rd_count_pre", rd_count, 0);
        tick();
        chk("ld_rd_count", rd_count, 1);
        chk("ld_wr_count", wr_count, 1);
        chk("ld_rd_pulses", rd_pulses - p0, 1);

        // load stalled by rsp_ready low, with req_valid left asserted
        p0 = rd_pulses;
        w0 = wr_pulses;
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 5;
        tick();
        req_addr = 9; req_we = 1'b1;
        tick();
        tick();
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("stall_valid_%0d", i), rsp_valid, 1);
            chk($sformatf("stall_rdata_%0d", i), rsp_rdata, 32'h1234A);
            chk($sformatf("stall_ready_%0d", i), req_ready, 0);
            chk($sformatf("stall_addr_%0d", i), address, 5);
            tick();
        end
        chk("stall_still_valid", rsp_valid, 1);
        rsp_ready = 1'b1;
        req_valid = 1'b0;
        tick();
        chk("stall_rd_count", rd_count, 2);
        chk("stall_rd_pulses", rd_pulses - p0, 1);
        chk("stall_wr_pulses", wr_pulses - w0, 0);
        chk("stall_idle", rsp_valid, 0);

        // reset while in READ_WAIT
        req_valid = 1'b1; req_we = 1'b0; req_addr = 5;
        tick();
        req_valid = 1'b0;
        tick();
        chk("rw_rd_en", RD_EN_DM, 0);
        chk("rw_rsp_valid", rsp_valid, 0);
        rst = 1'b1;
        tick();
        chk("rw_rst_valid", rsp_valid, 0);
        chk("rw_rst_ready", req_ready, 1);
        chk("rw_rst_rd_en", RD_EN_DM, 0);
        chk("rw_rst_wr_en", WR_EN_DM, 0);
        chk("rw_rst_rd_count", rd_count, 0);
        chk("rw_rst_rdata", rsp_rdata, 0);
        rst = 1'b0;
        tick();
        chk("rw_post_valid", rsp_valid, 0);
        chk("rw_post_rd_en", RD_EN_DM, 0);
        tick();
        chk("rw_dropped", rsp_valid, 0);
        chk("rw_rd_count", rd_count, 0);

        // last valid address
        req_valid = 1'b1; req_we = 1'b1; req_addr = 1023; req_wdata = 19'h70F0F;
        tick();
        req_valid = 1'b0;
        chk("b_wr_en", WR_EN_DM, 1);
        tick();
        tick();
        chk("b_wr_count", wr_count, 1);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 1023;
        tick();
        req_valid = 1'b0;
        chk("b_rd_en", RD_EN_DM, 1);
        tick();
        tick();
        chk("b_rsp_valid", rsp_valid, 1);
        chk("b_rdata", rsp_rdata, 32'h70F0F);
        chk("b_err", rsp_err, 0);
        tick();
        chk("b_rd_count", rd_count, 1);

        // first address past the end
        p0 = rd_pulses;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 1024;
        tick();
        req_valid = 1'b0;
`ifdef LSU_ADDR_CHECK_EN
        chk("e_rd_en", RD_EN_DM, 0);
        chk("e_rsp_valid", rsp_valid, 1);
        chk("e_err", rsp_err, 1);
        chk("e_rdata", rsp_rdata, 0);
        tick();
        chk("e_rd_count", rd_count, 1);
        chk("e_rd_pulses", rd_pulses - p0, 0);
        chk("e_idle", rsp_valid, 0);
`else
        chk("e_rd_en", RD_EN_DM, 1);
        tick();
        tick();
        chk("e_rsp_valid", rsp_valid, 1);
        chk("e_err", rsp_err, 0);
        chk("e_rdata", rsp_rdata, 0);
        tick();
        chk("e_rd_count", rd_count, 2);
        chk("e_rd_pulses", rd_pulses - p0, 1);
`endif

        // back-to-back stores: one per three cycles
        w0 = wr_pulses;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 20; req_wdata = 19'h00001;
        repeat (9) tick();
        req_valid = 1'b0;
        chk("bb_wr_pulses", wr_pulses - w0, 3);
        chk("bb_wr_count", wr_count, 4);
        chk("bb_ready", req_ready, 1);

        // saturation: preload near the top, then keep storing
        force dut.wr_count = 16'hFFFD;
        tick();
        release dut.wr_count;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 21; req_wdata = 19'h00002;
        repeat (3) tick();
        chk("sat_fffe", wr_count, 32'hFFFE);
        repeat (3) tick();
        chk("sat_ffff", wr_count, 32'hFFFF);
        repeat (3) tick();
        chk("sat_hold", wr_count, 32'hFFFF);
        repeat (3) tick();
        req_valid = 1'b0;
        chk("sat_hold2", wr_count, 32'hFFFF);
        tick();

        chk("no_dual_en", both_cycles, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
